// File: rtl/rvc_fetch.sv
// -----------------------------------------------------------------------------
// rvc_fetch -- instruction fetch front end for an RV32IC core.
//
// Drives word addresses to a synchronous instruction memory. Read data comes
// back one cycle after the address. The returned words are realigned into
// 16-bit compressed and 32-bit instructions, which go to decode one per
// valid/ready handshake. A 32-bit instruction that crosses a word boundary
// has its low half parked in a hold buffer while the next word is read.
//
// Optional feature macro: FETCH_RVC_EN
//   defined   : compressed / straddle realignment enabled
//   undefined : every word is a 32-bit instruction, PCs are word aligned
//
// Ports
//   clk                 clock, all state changes on posedge
//   reset               synchronous active-high reset
//   imem_addr           word address to the instruction memory
//   imem_rdata          read data for the address of the previous cycle
//   redirect_valid      PC redirect request (priority over all but reset)
//   redirect_pc         redirect target byte address
//   instr_valid         instr / instr_pc / instr_is_compressed valid
//   instr_ready         decode accepts the presented instruction
//   instr               instruction, compressed ones zero-extended
//   instr_pc            byte PC of instr
//   instr_is_compressed instr is a 16-bit instruction
// -----------------------------------------------------------------------------
module rvc_fetch #(
  parameter int          ADDR_WIDTH = 11,
  parameter int          DATA_WIDTH = 32,
  parameter logic [31:0] RESET_PC   = 32'h0000_0000
) (
  input  logic                  clk,
  input  logic                  reset,
  output logic [ADDR_WIDTH-1:0] imem_addr,
  input  logic [DATA_WIDTH-1:0] imem_rdata,
  input  logic                  redirect_valid,
  input  logic [31:0]           redirect_pc,
  output logic                  instr_valid,
  input  logic                  instr_ready,
  output logic [31:0]           instr,
  output logic [31:0]           instr_pc,
  output logic                  instr_is_compressed
);

  localparam logic RST_ISSUE = 1'b0;
  localparam logic RUN       = 1'b1;

  logic        fsm;
  logic [31:0] cur_pc;
  logic        cur_valid;

  logic        run;       // imem_rdata holds the word of cur_pc
  logic        cand_valid;
  logic [31:0] cand_instr;
  logic [31:0] cand_pc;
  logic        cand_comp;
  logic [31:0] pc_after;  // cur_pc after the candidate is accepted
  logic        transfer;
  logic        straddle;
  logic [31:0] redirect_target;
  logic [31:0] next_pc;

`ifdef FETCH_RVC_EN
  logic        hold_valid;
  logic [15:0] hold_half;
  logic [31:0] hold_pc;
  logic        off;
  assign off             = cur_pc[1];
  assign redirect_target = redirect_pc & 32'hFFFF_FFFE;
`else
  assign redirect_target = redirect_pc & 32'hFFFF_FFFC;
`endif

  assign run = (fsm == RUN) && cur_valid;

  // Candidate instruction decoded from the current word (and hold buffer).
  // NOTE: every signal gets a default at the top of always_comb so no path
  // leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    cand_valid = 1'b0;
    cand_instr = 32'h0;
    cand_pc    = cur_pc;
    cand_comp  = 1'b0;
    pc_after   = cur_pc;
    straddle   = 1'b0;
`ifdef FETCH_RVC_EN
    if (hold_valid) begin
      cand_valid = 1'b1;
      cand_instr = {imem_rdata[15:0], hold_half};
      cand_pc    = hold_pc;
      pc_after   = hold_pc + 32'd4;
    end else if (!off) begin
      cand_valid = 1'b1;
      if (imem_rdata[1:0] != 2'b11) begin
        cand_instr = {16'h0, imem_rdata[15:0]};
        cand_comp  = 1'b1;
        pc_after   = cur_pc + 32'd2;
      end else begin
        cand_instr = imem_rdata;
        pc_after   = cur_pc + 32'd4;
      end
    end else if (imem_rdata[17:16] != 2'b11) begin
      cand_valid = 1'b1;
      cand_instr = {16'h0, imem_rdata[31:16]};
      cand_comp  = 1'b1;
      pc_after   = cur_pc + 32'd2;
    end else begin
      // Upper half starts a 32-bit instruction: park it, read the next word.
      straddle = 1'b1;
      pc_after = cur_pc + 32'd2;
    end
`else
    cand_valid = 1'b1;
    cand_instr = imem_rdata;
    pc_after   = cur_pc + 32'd4;
`endif
  end

  always_comb begin
    instr_valid         = 1'b0;
    instr               = 32'h0;
    instr_pc            = 32'h0;
    instr_is_compressed = 1'b0;
    if (!reset && !redirect_valid && run && cand_valid) begin
      instr_valid         = 1'b1;
      instr               = cand_instr;
      instr_pc            = cand_pc;
      instr_is_compressed = cand_comp;
    end
  end

  assign transfer = instr_valid && instr_ready;

  // The memory registers the address, so the address driven now is the word
  // of the cur_pc value that will be loaded at this clock edge.
  always_comb begin
    next_pc = cur_pc;
    if (reset) begin
      next_pc = RESET_PC;
    end else if (redirect_valid) begin
      next_pc = redirect_target;
    end else if (run && (transfer || straddle)) begin
      next_pc = pc_after;
    end
  end

  assign imem_addr = next_pc[ADDR_WIDTH+1:2];

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      fsm       <= RST_ISSUE;
      cur_pc    <= RESET_PC;
      cur_valid <= 1'b0;
    end else begin
      cur_pc <= next_pc;
      if (redirect_valid || fsm == RST_ISSUE) begin
        fsm       <= RUN;
        cur_valid <= 1'b1;
      end
    end
  end

`ifdef FETCH_RVC_EN
  always_ff @(posedge clk) begin
    if (reset || redirect_valid) begin
      hold_valid <= 1'b0;
    end else if (run && straddle) begin
      hold_valid <= 1'b1;
    end else if (transfer) begin
      hold_valid <= 1'b0;
    end
  end

  // NOTE: the hold payload is not reset; it is only ever read while
  // hold_valid is set, and hold_valid is cleared by reset.
  always_ff @(posedge clk) begin
    if (run && straddle && !reset && !redirect_valid) begin
      hold_half <= imem_rdata[31:16];
      hold_pc   <= cur_pc;
    end
  end
`endif

endmodule

// File: tb/tb_rvc_fetch.sv
// -----------------------------------------------------------------------------
// tb_rvc_fetch -- bench for rvc_fetch with a 16-word synchronous memory.
// Directed per-cycle vectors cover the documented scenarios; a randomized
// phase compares every handshake against an instruction-stream model that
// decodes straight from the memory image.
// -----------------------------------------------------------------------------
module tb_rvc_fetch;

  localparam int AW = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic [AW-1:0] imem_addr;
  logic [31:0]   imem_rdata;
  logic          redirect_valid;
  logic [31:0]   redirect_pc;
  logic          instr_valid;
  logic          instr_ready;
  logic [31:0]   instr;
  logic [31:0]   instr_pc;
  logic          instr_is_compressed;

  logic [31:0] mem [0:(1<<AW)-1];

  int n_pass  = 0;
  int n_total = 0;

  rvc_fetch #(.ADDR_WIDTH(AW), .DATA_WIDTH(32), .RESET_PC(32'h0)) dut (
    .clk                 (clk),
    .reset               (reset),
    .imem_addr           (imem_addr),
    .imem_rdata          (imem_rdata),
    .redirect_valid      (redirect_valid),
    .redirect_pc         (redirect_pc),
    .instr_valid         (instr_valid),
    .instr_ready         (instr_ready),
    .instr               (instr),
    .instr_pc            (instr_pc),
    .instr_is_compressed (instr_is_compressed)
  );

  always #5 clk = ~clk;

  always @(posedge clk) imem_rdata <= mem[imem_addr];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
  endtask

  typedef struct {
    logic        rst;
    logic        rdy;
    logic        redir;
    logic [31:0] tgt;
    logic        ev;
    logic [31:0] ei;
    logic [31:0] ep;
    logic        ec;
    logic [31:0] ea;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic rst, input logic rdy, input logic redir, input logic [31:0] tgt,
                     input logic ev, input logic [31:0] ei, input logic [31:0] ep,
                     input logic ec, input logic [31:0] ea);
    vec_t v;
    v.rst = rst; v.rdy = rdy; v.redir = redir; v.tgt = tgt;
    v.ev = ev; v.ei = ei; v.ep = ep; v.ec = ec; v.ea = ea;
    vecs.push_back(v);
  endtask

  // Reference model: halfword at a byte PC of the memory image.
  function automatic logic [15:0] half_at(input logic [31:0] pc);
    logic [31:0] w;
    w = mem[pc[AW+1:2]];
    return pc[1] ? w[31:16] : w[15:0];
  endfunction

  initial begin
    logic [31:0] mpc;
    logic [31:0] exp_i;
    logic [31:0] exp_len;
    logic        exp_c;
    logic [31:0] tgt;
    logic        rdy, redir;
    int          bubbles;

    reset = 1'b1; instr_ready = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'h0;
    mem[0] = 32'h0093_4585;
    mem[1] = 32'h4505_0050;
    mem[2] = 32'h0050_0093;
    mem[3] = 32'h4505_4585;
    mem[4] = 32'h4585_0001;
    for (int i = 5; i < (1 << AW); i++) mem[i] = 32'h0000_0013;

    //   rst rdy rdr  tgt    ev  instr          pc     c  addr
`ifdef FETCH_RVC_EN
    add(1, 1, 0, 0,     0, 0,             0,     0, 0);  // in reset
    add(0, 1, 0, 0,     0, 0,             0,     0, 0);  // RST_ISSUE
    add(0, 1, 0, 0,     1, 32'h4585,      0,     1, 0);
    add(0, 1, 0, 0,     0, 0,             0,     0, 1);  // straddle bubble
    add(0, 1, 0, 0,     1, 32'h00500093,  2,     0, 1);
    add(0, 1, 0, 0,     1, 32'h4505,      6,     1, 2);
    add(0, 0, 0, 0,     1, 32'h00500093,  8,     0, 2);  // stall x3
    add(0, 0, 0, 0,     1, 32'h00500093,  8,     0, 2);
    add(0, 0, 0, 0,     1, 32'h00500093,  8,     0, 2);
    add(0, 1, 0, 0,     1, 32'h00500093,  8,     0, 3);
    add(0, 0, 0, 0,     1, 32'h4585,      12,    1, 3);
    add(0, 0, 1, 32'h12, 0, 0,            0,     0, 4);  // redirect
    add(0, 1, 0, 0,     1, 32'h4585,      32'h12, 1, 5);
    add(0, 1, 1, 32'h3, 0, 0,             0,     0, 0);  // redirect to 2
    add(0, 1, 0, 0,     0, 0,             0,     0, 1);  // straddle bubble
    add(1, 1, 0, 0,     0, 0,             0,     0, 0);  // reset with hold set
    add(0, 1, 0, 0,     0, 0,             0,     0, 0);  // RST_ISSUE
    add(0, 1, 0, 0,     1, 32'h4585,      0,     1, 0);
`else
    add(1, 1, 0, 0,     0, 0,             0,     0, 0);
    add(0, 1, 0, 0,     0, 0,             0,     0, 0);
    add(0, 1, 0, 0,     1, 32'h00934585,  0,     0, 1);
    add(0, 1, 0, 0,     1, 32'h45050050,  4,     0, 2);
    add(0, 0, 0, 0,     1, 32'h00500093,  8,     0, 2);
    add(0, 0, 0, 0,     1, 32'h00500093,  8,     0, 2);
    add(0, 0, 0, 0,     1, 32'h00500093,  8,     0, 2);
    add(0, 1, 0, 0,     1, 32'h00500093,  8,     0, 3);
    add(0, 0, 0, 0,     1, 32'h45054585,  12,    0, 3);
    add(0, 0, 1, 32'h12, 0, 0,            0,     0, 4);
    add(0, 1, 0, 0,     1, 32'h45850001,  32'h10, 0, 5);
    add(1, 1, 0, 0,     0, 0,             0,     0, 0);
    add(0, 1, 0, 0,     0, 0,             0,     0, 0);
    add(0, 1, 0, 0,     1, 32'h00934585,  0,     0, 1);
`endif

    foreach (vecs[k]) begin
      @(negedge clk);
      reset = vecs[k].rst; instr_ready = vecs[k].rdy;
      redirect_valid = vecs[k].redir; redirect_pc = vecs[k].tgt;
      #1;
      check($sformatf("vec%0d valid", k), {31'h0, instr_valid}, {31'h0, vecs[k].ev});
      check($sformatf("vec%0d addr", k), {{(32-AW){1'b0}}, imem_addr}, vecs[k].ea);
      if (vecs[k].ev) begin
        check($sformatf("vec%0d instr", k), instr, vecs[k].ei);
        check($sformatf("vec%0d pc", k), instr_pc, vecs[k].ep);
        check($sformatf("vec%0d comp", k), {31'h0, instr_is_compressed}, {31'h0, vecs[k].ec});
      end
      if (vecs[k].rst) begin
        check($sformatf("vec%0d rst instr", k), instr, 32'h0);
        check($sformatf("vec%0d rst pc", k), instr_pc, 32'h0);
      end
    end

    // Randomized phase: fresh image, reset, random ready and redirects.
    for (int i = 0; i < (1 << AW); i++) mem[i] = $urandom;
    @(negedge clk);
    reset = 1'b1; redirect_valid = 1'b0; instr_ready = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    mpc = 32'h0;
    bubbles = 0;
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      redir = ($urandom_range(0, 19) == 0);
      rdy   = ($urandom_range(0, 3) != 0);
      tgt   = $urandom_range(0, 255);
      redirect_valid = redir; instr_ready = rdy; redirect_pc = tgt;
      #1;
`ifdef FETCH_RVC_EN
      if (half_at(mpc) % 4 != 3) begin
        exp_i = {16'h0, half_at(mpc)}; exp_c = 1'b1; exp_len = 2;
      end else begin
        exp_i = {half_at(mpc + 2), half_at(mpc)}; exp_c = 1'b0; exp_len = 4;
      end
`else
      exp_i = mem[mpc[AW+1:2]]; exp_c = 1'b0; exp_len = 4;
`endif
      if (redir) begin
        check("rnd redirect valid", {31'h0, instr_valid}, 32'h0);
        check("rnd redirect addr", {{(32-AW){1'b0}}, imem_addr}, (tgt >> 2) % (1 << AW));
`ifdef FETCH_RVC_EN
        mpc = tgt & 32'hFFFF_FFFE;
`else
        mpc = tgt & 32'hFFFF_FFFC;
`endif
        bubbles = 0;
      end else if (instr_valid) begin
        check("rnd instr", instr, exp_i);
        check("rnd pc", instr_pc, mpc);
        check("rnd comp", {31'h0, instr_is_compressed}, {31'h0, exp_c});
        if (rdy) mpc = mpc + exp_len;
        else check("rnd stall addr", {{(32-AW){1'b0}}, imem_addr},
                   ((mpc + exp_len - 2) >> 2) % (1 << AW));
        bubbles = 0;
      end else begin
        bubbles++;
        check("rnd bubble bound", {31'h0, bubbles > 2}, 32'h0);
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
